spi_slave: RTL and testbench
============================

# spi_slave

Receive-side counterpart of the team's 16-bit SPI master. It is a mode-0 SPI responder clocked by the system clock. It oversamples the master's `spi_cs`, `spi_clk` and `spi_data` lines, shifts the received frame into `rx_data`, and drives its own frame back on `miso`. It sits on the same board-level link as the master, and loopback benches connect it directly to the master's pins.

## Interface
Parameters:
- `DATA_W`, 16: frame length in bits. MSB is sent first.
- `SYNC_STAGES`, 2: synchronizer depth on `spi_cs`, `spi_clk` and `mosi`. Minimum value is 2.

Ports:
- `clk`  in  1  system clock. It is the only clock in the block.
- `reset`  in  1  asynchronous, active-high reset.
- `spi_cs`  in  1  chip select from the master. Active low.
- `spi_clk`  in  1  serial clock from the master. Idles low (CPOL=0).
- `mosi`  in  1  serial data from the master, i.e. the master's `spi_data`.
- `miso`  out  1  serial data to the master, i.e. the master's `master_data`.
- `tx_data`  in  DATA_W  word to return. Captured at frame start.
- `rx_data`  out  DATA_W  last complete received word.
- `rx_valid`  out  1  one-cycle pulse when a new word is in `rx_data`.
- `frame_err`  out  1  one-cycle pulse when CS deasserts mid-frame or more than DATA_W bits are clocked.
- `busy`  out  1  high while a frame is in progress.
- `bit_count`  out  5  bits received in the current frame, from 0 to DATA_W.

## Operation
- Each of `spi_cs`, `spi_clk` and `mosi` passes through `SYNC_STAGES` flops, then one history flop for edge detection.
- Detected events:
  - `cs_fall`: synchronized CS goes 1→0.
  - `cs_rise`: synchronized CS goes 0→1.
  - `sck_rise` and `sck_fall`: edges of synchronized `spi_clk`. These are only counted while synchronized CS is low.
- State machine:
  - IDLE: `busy`=0 and `miso`=0. On `cs_fall`: load `tx_data` into tx_shift, clear `bit_count`, go to SHIFT.
  - SHIFT: `busy`=1.
    - On `sck_rise`: rx_shift = {rx_shift[DATA_W-2:0], mosi_sync} and `bit_count`+1.
    - On `sck_fall`: tx_shift <<= 1, fill bit 0.
    - When `bit_count` reaches DATA_W: copy rx_shift to `rx_data`, pulse `rx_valid`, go to DONE.
    - On `cs_rise` with `bit_count` < DATA_W: pulse `frame_err`, leave `rx_data` unchanged, go to IDLE. If `bit_count`=0, no error is raised (empty select).
  - DONE: `busy`=1 and `miso` is held at 0.
    - An extra `sck_rise` pulses `frame_err` once per frame. `rx_data` is unaffected.
    - On `cs_rise`: go to IDLE.
- `miso` = tx_shift[DATA_W-1] in SHIFT and 0 otherwise. It is never tri-stated.
- `cs_fall` and `cs_rise` take priority over clock edges in the same cycle.
- `bit_count` saturates at DATA_W and wraps to 0 only on the next `cs_fall`.
- Reset mid-frame: all state returns to IDLE at once. A frame still in progress after reset release is ignored until the next `cs_fall`.

## Timing
- Reset values: `miso`=0, `rx_data`=0, `rx_valid`=0, `frame_err`=0, `busy`=0, `bit_count`=0, state=IDLE.
- Pin-to-event latency is SYNC_STAGES+1 cycles.
- `miso` changes 1 cycle after the event, so pin-to-`miso` latency is SYNC_STAGES+2 cycles (4 cycles at the default).
- `rx_valid` asserts 1 cycle after the DATA_W-th `sck_rise` event. `rx_data` is stable from that same cycle.
- The first `miso` bit is valid SYNC_STAGES+2 cycles after `spi_cs` falls.
- Link requirements:
  - `spi_clk` high and low phases are each at least SYNC_STAGES+3 `clk` cycles.
  - CS setup to the first `spi_clk` rise is at least SYNC_STAGES+3 cycles.
  - `mosi` is stable at least SYNC_STAGES cycles around each `spi_clk` rise.
- The master must meet these or slow its `spi_clk`.
- `tx_data` must be stable in the cycle `cs_fall` is detected. Later changes do not affect the current frame.

## Structure
- `spi_pkg`: DATA_W default, state encodings IDLE/SHIFT/DONE, and the `bit_count` width. The master shares this package.
- Sub-module `spi_sync`: a SYNC_STAGES flop chain plus a history flop, outputting the level, rise and fall. It is instantiated three times.
- The top level holds the FSM, both shift registers and the counter.

## Test plan
- Reset, then master sends 16'hA569 with `tx_data`=16'h3425. Required: `rx_data`=16'hA569, one `rx_valid` pulse, master receives 16'h3425, `bit_count`=16.
- Back-to-back frames: 16'h2563/16'h0001, then 16'h9B63/16'hA569. Required: each frame reloads `tx_data`, two `rx_valid` pulses, and values match per frame.
- CS deasserts after 7 bits of 16'h6A61. Required: one `frame_err` pulse, `rx_data` keeps its previous value, no `rx_valid`, and the next full frame 16'h9B22 is received correctly.
- 17 `spi_clk` rises within one CS window. Required: `rx_valid` after bit 16 with the correct word, then one `frame_err`, and `miso`=0 during bit 17.
- `reset` asserted at bit 8 of a frame. Required: all outputs return to reset values immediately, and the remainder of that frame produces no `rx_valid`.
- `tx_data` changed from 16'hFFFF to 16'h0000 mid-frame. Required: master still receives 16'hFFFF.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the 16-bit SPI master/slave pair.
package spi_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int CNT_W      = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/spi_sync.sv
// Synchronizer chain plus one history flop, giving the settled level and its edges.
module spi_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_chain;
  logic              r_hist;

  // Resetting to 0 means a CS line already low at reset release never fakes a cs_fall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_chain <= '0;
      r_hist  <= 1'b0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_async};
      r_hist  <= r_chain[STAGES-1];
    end
  end

  assign o_level = r_chain[STAGES-1];
  assign o_rise  = r_chain[STAGES-1] & ~r_hist;
  assign o_fall  = ~r_chain[STAGES-1] & r_hist;

endmodule

// File: rtl/spi_slave.sv
// Mode-0 SPI responder running on the system clock; oversamples the master's pins.
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_cs,
  input  logic              spi_clk,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_err,
  output logic              busy,
  output logic [CNT_W-1:0]  bit_count
);

  logic w_csLvl, w_csRise, w_csFall;
  logic w_unusedSckLvl, w_sckRise, w_sckFall;
  logic w_mosiLvl, w_unusedMosiRise, w_unusedMosiFall;
  logic w_sckRiseCs, w_sckFallCs;
  logic w_load, w_shiftIn, w_shiftOut, w_complete, w_errPulse;

  state_t            r_state, w_nextState;
  logic [DATA_W-1:0] r_txShift, r_rxShift, r_rxData;
  logic [CNT_W-1:0]  r_bitCount;
  logic              r_miso, r_rxValid, r_frameErr, r_extraSeen;

  spi_sync #(.STAGES(SYNC_STAGES)) u_csSync (
    .clk(clk), .reset(reset), .i_async(spi_cs),
    .o_level(w_csLvl), .o_rise(w_csRise), .o_fall(w_csFall)
  );

  spi_sync #(.STAGES(SYNC_STAGES)) u_sckSync (
    .clk(clk), .reset(reset), .i_async(spi_clk),
    .o_level(w_unusedSckLvl), .o_rise(w_sckRise), .o_fall(w_sckFall)
  );

  spi_sync #(.STAGES(SYNC_STAGES)) u_mosiSync (
    .clk(clk), .reset(reset), .i_async(mosi),
    .o_level(w_mosiLvl), .o_rise(w_unusedMosiRise), .o_fall(w_unusedMosiFall)
  );

  assign w_sckRiseCs = w_sckRise & ~w_csLvl;
  assign w_sckFallCs = w_sckFall & ~w_csLvl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  // CS edges are tested first so they win over a clock edge in the same cycle.
  always_comb begin
    w_nextState = r_state;
    w_load      = 1'b0;
    w_shiftIn   = 1'b0;
    w_shiftOut  = 1'b0;
    w_complete  = 1'b0;
    w_errPulse  = 1'b0;
    busy        = (r_state != IDLE);
    unique case (r_state)
      IDLE: begin
        if (w_csFall) begin
          w_load      = 1'b1;
          w_nextState = SHIFT;
        end
      end
      SHIFT: begin
        if (w_csRise) begin
          w_nextState = IDLE;
          w_errPulse  = (r_bitCount != '0);
        end else if (w_sckRiseCs) begin
          w_shiftIn = 1'b1;
          if (r_bitCount == CNT_W'(DATA_W - 1)) begin
            w_complete  = 1'b1;
            w_nextState = DONE;
          end
        end else if (w_sckFallCs) begin
          w_shiftOut = 1'b1;
        end
      end
      DONE: begin
        if (w_csRise)                         w_nextState = IDLE;
        else if (w_sckRiseCs && !r_extraSeen) w_errPulse  = 1'b1;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // The final bit goes straight into rx_data so rx_valid lands one cycle after the last rise event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_txShift   <= '0;
      r_rxShift   <= '0;
      r_rxData    <= '0;
      r_bitCount  <= '0;
      r_miso      <= 1'b0;
      r_rxValid   <= 1'b0;
      r_frameErr  <= 1'b0;
      r_extraSeen <= 1'b0;
    end else begin
      r_rxValid  <= w_complete;
      r_frameErr <= w_errPulse;
      r_miso     <= (r_state == SHIFT) ? r_txShift[DATA_W-1] : 1'b0;
      if (w_load) begin
        r_txShift   <= tx_data;
        r_bitCount  <= '0;
        r_extraSeen <= 1'b0;
      end
      if (w_shiftIn) begin
        r_rxShift  <= {r_rxShift[DATA_W-2:0], w_mosiLvl};
        r_bitCount <= r_bitCount + CNT_W'(1);
      end
      if (w_shiftOut) r_txShift <= {r_txShift[DATA_W-2:0], 1'b0};
      if (w_complete) r_rxData  <= {r_rxShift[DATA_W-2:0], w_mosiLvl};
      if (w_errPulse && r_state == DONE) r_extraSeen <= 1'b1;
    end
  end

  assign miso      = r_miso;
  assign rx_data   = r_rxData;
  assign rx_valid  = r_rxValid;
  assign frame_err = r_frameErr;
  assign bit_count = r_bitCount;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a bit-banged mode-0 master plus a word-level model of what each frame should yield.
module tb_spi_slave;

  localparam int HALF  = 6;
  localparam int SETUP = 8;
  localparam int GAP   = 10;

  typedef struct {
    logic [15:0] mosiWord;
    logic [15:0] txWord;
    logic [15:0] midTx;
    int          nBits;
    logic [15:0] expRx;
    int          expValid;
    int          expErr;
    logic [31:0] expMiso;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, spi_cs, spi_clk, mosi, miso;
  logic        rx_valid, frame_err, busy;
  logic [15:0] tx_data, rx_data;
  logic [4:0]  bit_count;

  int          checks = 0;
  int          failures = 0;
  int          validCount = 0;
  int          errCount = 0;
  logic [15:0] pulseData = '0;

  always #5 clk = ~clk;

  spi_slave #(.DATA_W(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .spi_cs(spi_cs), .spi_clk(spi_clk),
    .mosi(mosi), .miso(miso), .tx_data(tx_data), .rx_data(rx_data),
    .rx_valid(rx_valid), .frame_err(frame_err), .busy(busy),
    .bit_count(bit_count)
  );

  // Pulse counters; a pulse stretched past one cycle shows up as an extra count.
  always @(negedge clk) begin
    if (rx_valid) begin
      validCount = validCount + 1;
      pulseData  = rx_data;
    end
    if (frame_err) errCount = errCount + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks = checks + 1;
    if (actual !== expected) begin
      failures = failures + 1;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Plays the master for one CS window of nBits clocks; returns what it sampled on miso.
  task automatic applyStimulus(input logic [15:0] mosiWord, input logic [15:0] txWord,
                               input logic [15:0] midTx, input int nBits, input string tag,
                               output logic [31:0] misoBits);
    misoBits = '0;
    tx_data  = txWord;
    spi_cs   = 1'b0;
    repeat (SETUP) @(negedge clk);
    for (int b = 0; b < nBits; b++) begin
      if (b == 8) tx_data = midTx;
      mosi = (b < 16) ? mosiWord[15-b] : 1'b1;
      repeat (HALF) @(negedge clk);
      if (b == 8) begin
        checkOutput({tag, ".midCount"}, 32'(bit_count), 32'd8);
        checkOutput({tag, ".midBusy"}, 32'(busy), 32'd1);
      end
      misoBits = {misoBits[30:0], miso};
      spi_clk  = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_clk = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    checkOutput({tag, ".endCount"}, 32'(bit_count), (nBits > 16) ? 32'd16 : 32'(nBits));
    checkOutput({tag, ".endBusy"}, 32'(busy), 32'd1);
    spi_cs = 1'b1;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic runFrame(input vec_t v, input string tag);
    int          v0, e0;
    logic [31:0] got;
    v0 = validCount;
    e0 = errCount;
    applyStimulus(v.mosiWord, v.txWord, v.midTx, v.nBits, tag, got);
    checkOutput({tag, ".rxValid"}, 32'(validCount - v0), 32'(v.expValid));
    checkOutput({tag, ".frameErr"}, 32'(errCount - e0), 32'(v.expErr));
    checkOutput({tag, ".rxData"}, 32'(rx_data), 32'(v.expRx));
    checkOutput({tag, ".miso"}, got, v.expMiso);
    checkOutput({tag, ".idleBusy"}, 32'(busy), 32'd0);
    if (v.expValid != 0) checkOutput({tag, ".pulseData"}, 32'(pulseData), 32'(v.expRx));
  endtask

  function automatic logic [31:0] misoModel(input logic [15:0] tx, input int n);
    if (n == 0)  return 32'd0;
    if (n <= 16) return 32'(tx) >> (16 - n);
    return 32'(tx) << (n - 16);
  endfunction

  initial begin
    vec_t        vecs[8];
    vec_t        rv;
    logic [15:0] lastRx;
    logic [31:0] junk;
    int          v0, e0;

    vecs[0] = '{16'hA569, 16'h3425, 16'h3425, 16, 16'hA569, 1, 0, 32'h3425};
    vecs[1] = '{16'h2563, 16'h0001, 16'h0001, 16, 16'h2563, 1, 0, 32'h0001};
    vecs[2] = '{16'h9B63, 16'hA569, 16'hA569, 16, 16'h9B63, 1, 0, 32'hA569};
    vecs[3] = '{16'h6A61, 16'hF0F0, 16'hF0F0,  7, 16'h9B63, 0, 1, 32'h78};
    vecs[4] = '{16'h9B22, 16'h1234, 16'h1234, 16, 16'h9B22, 1, 0, 32'h1234};
    vecs[5] = '{16'h5A3C, 16'hC3A5, 16'hC3A5, 17, 16'h5A3C, 1, 1, 32'h1874A};
    vecs[6] = '{16'h1111, 16'h2222, 16'h2222,  0, 16'h5A3C, 0, 0, 32'h0};
    vecs[7] = '{16'h7E81, 16'hFFFF, 16'h0000, 16, 16'h7E81, 1, 0, 32'hFFFF};

    reset   = 1'b1;
    spi_cs  = 1'b1;
    spi_clk = 1'b0;
    mosi    = 1'b0;
    tx_data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset.miso", 32'(miso), 32'd0);
    checkOutput("reset.rxData", 32'(rx_data), 32'd0);
    checkOutput("reset.rxValid", 32'(rx_valid), 32'd0);
    checkOutput("reset.frameErr", 32'(frame_err), 32'd0);
    checkOutput("reset.busy", 32'(busy), 32'd0);
    checkOutput("reset.bitCount", 32'(bit_count), 32'd0);
    repeat (GAP) @(negedge clk);

    for (int i = 0; i < 8; i++) runFrame(vecs[i], $sformatf("vec%0d", i));

    // Reset pulled halfway through a frame; the tail of that frame must be ignored.
    v0 = validCount;
    e0 = errCount;
    tx_data = 16'hBEEF;
    spi_cs  = 1'b0;
    repeat (SETUP) @(negedge clk);
    for (int b = 0; b < 16; b++) begin
      mosi = b[0];
      repeat (HALF) @(negedge clk);
      if (b == 8) begin
        reset = 1'b1;
        #1;
        checkOutput("midReset.miso", 32'(miso), 32'd0);
        checkOutput("midReset.rxData", 32'(rx_data), 32'd0);
        checkOutput("midReset.busy", 32'(busy), 32'd0);
        checkOutput("midReset.bitCount", 32'(bit_count), 32'd0);
        checkOutput("midReset.rxValid", 32'(rx_valid), 32'd0);
        checkOutput("midReset.frameErr", 32'(frame_err), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
      end
      spi_clk = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_clk = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    checkOutput("midReset.tailBusy", 32'(busy), 32'd0);
    spi_cs = 1'b1;
    repeat (GAP) @(negedge clk);
    checkOutput("midReset.noValid", 32'(validCount - v0), 32'd0);
    checkOutput("midReset.noErr", 32'(errCount - e0), 32'd0);
    checkOutput("midReset.rxKept", 32'(rx_data), 32'd0);

    // Randomized frames against the word-level model.
    lastRx = 16'h0000;
    for (int i = 0; i < 20; i++) begin
      rv.mosiWord = 16'($urandom);
      rv.txWord   = 16'($urandom);
      rv.midTx    = 16'($urandom);
      rv.nBits    = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 18)) : 16;
      rv.expValid = (rv.nBits >= 16) ? 1 : 0;
      rv.expErr   = ((rv.nBits >= 1 && rv.nBits <= 15) || rv.nBits >= 17) ? 1 : 0;
      rv.expRx    = (rv.nBits >= 16) ? rv.mosiWord : lastRx;
      rv.expMiso  = misoModel(rv.txWord, rv.nBits);
      lastRx      = rv.expRx;
      runFrame(rv, $sformatf("rnd%0d", i));
    end

    applyStimulus(16'hC001, 16'h5555, 16'h5555, 16, "final", junk);
    checkOutput("final.miso", junk, 32'h5555);
    checkOutput("final.rxData", 32'(rx_data), 32'hC001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
